// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the register file: pipeline write-back has priority, auxiliary
// writes queue in a small FIFO and drain into idle cycles. Optional macro: RWA_STARVE_EN.
module reg_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int AW           = 4,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_dest,
    input  logic [DW-1:0]          wb_value,
    input  logic                   aux_valid,
    output logic                   aux_ready,
    input  logic [AW-1:0]          aux_dest,
    input  logic [DW-1:0]          aux_value,
    input  logic [AW-1:0]          src1,
    input  logic [AW-1:0]          src2,
    output logic                   hazard1,
    output logic                   hazard2,
    output logic                   rf_wb_en,
    output logic [AW-1:0]          rf_dest,
    output logic [DW-1:0]          rf_value,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   stall_req
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    dest_r  [DEPTH];
    logic [DW-1:0]    value_r [DEPTH];
    logic [DEPTH-1:0] live_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             ready_r;
    logic             rf_wb_en_r;
    logic [AW-1:0]    rf_dest_r;
    logic [DW-1:0]    rf_value_r;

    logic             head_valid_s;
    logic             head_live_s;
    logic             push_s;
    logic             pop_s;
    logic             nxt_wb_en_s;
    logic [AW-1:0]    nxt_dest_s;
    logic [DW-1:0]    nxt_value_s;
    logic [CW-1:0]    count_nxt_s;
    logic             hazard1_s;
    logic             hazard2_s;

    // Grant decision: write-back first, then a live head; a dead head is discarded either way.
    always_comb begin
        head_valid_s = (count_r != CW'(0));
        head_live_s  = head_valid_s && live_r[rd_ptr_r];
        push_s       = aux_valid && ready_r;
        pop_s        = 1'b0;
        nxt_wb_en_s  = 1'b0;
        nxt_dest_s   = {AW{1'b0}};
        nxt_value_s  = {DW{1'b0}};
        if (wb_en) begin
            nxt_wb_en_s = 1'b1;
            nxt_dest_s  = wb_dest;
            nxt_value_s = wb_value;
            pop_s       = head_valid_s && !head_live_s;
        end else if (head_live_s) begin
            nxt_wb_en_s = 1'b1;
            nxt_dest_s  = dest_r[rd_ptr_r];
            nxt_value_s = value_r[rd_ptr_r];
            pop_s       = 1'b1;
        end else begin
            pop_s       = head_valid_s;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Read-operand hazard: any live queued write to the decoded source registers.
    always_comb begin
        hazard1_s = 1'b0;
        hazard2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard1_s = hazard1_s | (live_r[i] && (dest_r[i] == src1));
            hazard2_s = hazard2_s | (live_r[i] && (dest_r[i] == src2));
        end
    end

    // Queue control: pointers, occupancy, live bits (kill, then pop, then push).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b0;
            live_r   <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_en && (dest_r[i] == wb_dest)) begin
                    live_r[i] <= 1'b0;
                end
            end
            if (pop_s) begin
                live_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r         <= rd_ptr_r + PW'(1);
            end
            if (push_s) begin
                live_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s < CW'(DEPTH));
        end
    end

    // Payload storage needs no reset; validity is carried by count_r and live_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            dest_r[wr_ptr_r]  <= aux_dest;
            value_r[wr_ptr_r] <= aux_value;
        end
    end

    // Registered write command toward the register file write-back inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wb_en_r <= 1'b0;
            rf_dest_r  <= {AW{1'b0}};
            rf_value_r <= {DW{1'b0}};
        end else begin
            rf_wb_en_r <= nxt_wb_en_s;
            rf_dest_r  <= nxt_dest_s;
            rf_value_r <= nxt_value_s;
        end
    end

`ifdef RWA_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] wait_r;
    logic [SW-1:0] wait_nxt_s;
    logic          stall_r;

    // Wait counter: counts edges a live head is held off by write-back, saturating at the limit.
    always_comb begin
        if (pop_s || !head_valid_s) begin
            wait_nxt_s = {SW{1'b0}};
        end else if (head_live_s && (wait_r != SW'(STARVE_LIMIT))) begin
            wait_nxt_s = wait_r + SW'(1);
        end else begin
            wait_nxt_s = wait_r;
        end
    end

    // Bubble request held until the head finally drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_r  <= {SW{1'b0}};
            stall_r <= 1'b0;
        end else begin
            wait_r  <= wait_nxt_s;
            stall_r <= (wait_nxt_s == SW'(STARVE_LIMIT));
        end
    end

    assign stall_req = stall_r;
`else
    assign stall_req = (STARVE_LIMIT < 0) ? 1'b1 : 1'b0;
`endif

    assign aux_ready = ready_r;
    assign hazard1   = hazard1_s;
    assign hazard2   = hazard2_s;
    assign rf_wb_en  = rf_wb_en_r;
    assign rf_dest   = rf_dest_r;
    assign rf_value  = rf_value_r;
    assign q_count   = count_r;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Arbiter and scheduler for the register file's single write port. It shares that port between the pipeline write-back stage and a long-latency auxiliary requester, such as a multiplier or a load-multiple sequencer. The pipeline always has priority. Auxiliary writes wait in a small FIFO and drain into free write-back cycles. The block also flags read operands that still have a pending auxiliary write, and it presents a registered write command that connects directly to the register file's write-back inputs (WB_EN, destWB, valueWB).

## Interface
- DEPTH, 4, auxiliary FIFO entries (power of 2, ≥2)
- AW, 4, register address width
- DW, 32, data width
- STARVE_LIMIT, 8, cycles an auxiliary head may wait before a bubble is requested (only with RWA_STARVE_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- wb_en  in  1  pipeline write-back request
- wb_dest  in  AW  pipeline destination register
- wb_value  in  DW  pipeline write data
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  FIFO can accept; a transfer occurs when aux_valid && aux_ready at the clock edge
- aux_dest  in  AW  auxiliary destination
- aux_value  in  DW  auxiliary data
- src1, src2  in  AW  read addresses being decoded
- hazard1, hazard2  out  1  a live queued write targets src1 / src2 (combinational)
- rf_wb_en  out  1  registered write enable to the register file
- rf_dest  out  AW  registered write address
- rf_value  out  DW  registered write data
- q_count  out  log2(DEPTH)+1  live and dead FIFO occupancy
- stall_req  out  1  request one write-back bubble (RWA_STARVE_EN only; otherwise tied 0)

## Operation
- Each FIFO entry holds {dest, value, live}. Push sets live=1. aux_ready = (q_count < DEPTH).
- Per-cycle grant, decided combinationally and registered at the edge:
  - wb_en=1: grant WB. rf_* ← {1, wb_dest, wb_value}.
  - else, head live: grant aux. rf_* ← {1, head.dest, head.value}; pop.
  - else, head dead: pop silently; rf_* ← {0, 0, 0}.
  - else (FIFO empty): rf_* ← {0, 0, 0}.
  - A dead head is also popped in a cycle where WB is granted. A live head is never popped while WB is granted.
- Ordering (kill rule): a WB grant to register R clears live on every queued entry with dest R, because the pipeline write is younger. An entry pushed in the same cycle with aux_dest = wb_dest is enqueued live.
- Push and pop in the same cycle are both honoured; q_count is unchanged.
- hazardN = 1 iff some live entry has dest == srcN. The incoming aux_* and the rf_* register are not included.
- Pointers wrap modulo DEPTH. Full and empty are decided by q_count, not by pointer equality.

## Timing
- Reset (rst=0, asynchronous): FIFO emptied, q_count=0, rf_wb_en=0, rf_dest=0, rf_value=0, aux_ready=0, stall_req=0, starvation counter=0. These values hold for the whole time rst is low; any in-flight queue content is discarded.
- aux_ready rises in the first cycle after rst deasserts.
- WB latency: wb_* sampled at edge N appears on rf_* during cycle N+1.
- Aux latency: pushed at edge N, earliest appearance on rf_* is cycle N+2 (FIFO empty, wb_en low in cycle N+1).
- Kill and hazard updates take effect from the edge that performs the WB grant.

## Configuration
- RWA_STARVE_EN defined: a wait counter runs while the head is live and not granted; it resets on pop or when the FIFO is empty.
  - Counter reaching STARVE_LIMIT asserts stall_req (registered) until the head is granted.
  - The hazard unit must hold wb_en=0 in the cycle after stall_req is first seen.
  - Counter width is clog2(STARVE_LIMIT+1).
- RWA_STARVE_EN undefined: no counter; stall_req is constant 0. Auxiliary progress relies on natural write-back bubbles.

## Test plan
- Reset then idle: rst low for 2 cycles → all outputs 0; aux_ready=1 one cycle after release; rf_wb_en stays 0.
- WB passthrough: wb_en=1, wb_dest=1, wb_value=2 at edge N → rf_wb_en=1, rf_dest=1, rf_value=2 in cycle N+1; 0 in cycle N+2 with wb_en dropped.
- Aux drain with priority: push aux (dest=2, value=4) while wb_en=1 for 3 cycles → hazard1=1 with src1=2 during those cycles; aux write appears the cycle after wb_en falls; hazard1 then 0.
- Full FIFO: push DEPTH entries with wb_en=1 → aux_ready=0, q_count=DEPTH; drop wb_en for one cycle → one pop, aux_ready=1; simultaneous push keeps q_count=DEPTH.
- Kill rule: queue aux dest=3 value=9, then WB dest=3 value=7 → rf shows value 7 only; dead entry popped without rf_wb_en; hazard for src=3 clears at the WB edge.
- Starvation (RWA_STARVE_EN, STARVE_LIMIT=8): queue one entry and hold wb_en=1 → stall_req=1 after 8 waiting cycles; bench drops wb_en → entry written, stall_req=0 next cycle. Mid-test rst pulse → FIFO empty, stall_req=0.
